// File: rtl/mcu0_intc_pkg.sv
// Shared types and constants for the mcu0 priority interrupt controller.
// Holds the source count, IRQ index width, ack timeout length, the mask
// reset value and the controller state encoding.
package mcu0_intc_pkg;

    localparam int unsigned NSRC        = 8;
    localparam int unsigned IRQ_W       = 3;
    localparam int unsigned ACK_TIMEOUT = 16;
    localparam int unsigned TO_W        = $clog2(ACK_TIMEOUT);

    localparam logic [NSRC-1:0] MASK_RESET = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

endpackage

// File: rtl/mcu0_intc_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
// Ports:
//   req     in  NSRC   request vector (bit 0 is highest priority)
//   idx_c   out IRQ_W  index of the lowest set bit (0 when none set)
//   valid_c out 1      at least one request bit is set
import mcu0_intc_pkg::*;

module mcu0_intc_prio_enc (
    input  logic [NSRC-1:0]  req,
    output logic [IRQ_W-1:0] idx_c,
    output logic             valid_c
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c   = IRQ_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcu0_intc.sv
// Priority interrupt controller feeding the mcu0 core.
// Synchronizes NSRC asynchronous sources, latches rising edges as pending,
// masks them, and presents the highest-priority request (lowest index) to
// the core until ack; then tracks the in-service handler until eoi.
// Optional feature macro: INTC_TIMEOUT_EN -- withdraws an unacknowledged
// request after ACK_TIMEOUT cycles and sets the sticky timeout output.
// Ports:
//   clock       in  1     system clock, rising edge
//   reset       in  1     asynchronous active-high reset
//   src         in  NSRC  raw interrupt sources (rising-edge sensitive)
//   mask_we     in  1     mask write strobe
//   mask_wdata  in  NSRC  new mask value (1 = source disabled)
//   mask        out NSRC  current mask register
//   pending     out NSRC  current pending register
//   interrupt   out 1     request to core
//   irq         out IRQ_W index of the requested source
//   ack         in  1     core has taken the request
//   eoi         in  1     core executed IRET
//   in_service  out 1     a handler is active
//   timeout     out 1     sticky ack-timeout flag (INTC_TIMEOUT_EN only)
import mcu0_intc_pkg::*;

module mcu0_intc (
    input  logic             clock,
    input  logic             reset,
    input  logic [NSRC-1:0]  src,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_wdata,
    output logic [NSRC-1:0]  mask,
    output logic [NSRC-1:0]  pending,
    output logic             interrupt,
    output logic [IRQ_W-1:0] irq,
    input  logic             ack,
    input  logic             eoi,
`ifdef INTC_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             in_service
);

    logic [NSRC-1:0]  sync1;
    logic [NSRC-1:0]  sync2;
    logic [NSRC-1:0]  sync3;
    logic [NSRC-1:0]  rise;
    logic [NSRC-1:0]  clr_c;
    logic [IRQ_W-1:0] win_idx_c;
    logic             win_valid_c;
    state_t           state;
`ifdef INTC_TIMEOUT_EN
    logic [TO_W-1:0]  to_cnt;
`endif

    // Arbitration over unmasked pending bits, using the current (pre-write) mask.
    mcu0_intc_prio_enc u_prio_enc (
        .req     (pending & ~mask),
        .idx_c   (win_idx_c),
        .valid_c (win_valid_c)
    );

    // Two-flop synchronizer, edge flop and a registered rise pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            rise  <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
        end
    end

    // Pending bit retired by an accepted ack.
    always_comb begin
        clr_c = '0;
        if (state == REQ && ack) begin
            clr_c[irq] = 1'b1;
        end
    end

    // Mask, pending and request/service state machine.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask       <= MASK_RESET;
            pending    <= '0;
            interrupt  <= 1'b0;
            irq        <= '0;
            in_service <= 1'b0;
            state      <= IDLE;
`ifdef INTC_TIMEOUT_EN
            to_cnt     <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            if (mask_we) begin
                mask <= mask_wdata;
            end
            // A fresh edge in the ack cycle wins over the clear.
            pending <= (pending & ~clr_c) | rise;

            case (state)
                IDLE: begin
                    if (win_valid_c) begin
                        irq       <= win_idx_c;
                        interrupt <= 1'b1;
                        state     <= REQ;
`ifdef INTC_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ack) begin
                        interrupt  <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERV;
                    end
`ifdef INTC_TIMEOUT_EN
                    else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                        // Withdraw; pending stays set so the source re-arbitrates.
                        interrupt <= 1'b0;
                        timeout   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                SERV: begin
                    if (eoi) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu0_intc.sv
// Self-checking bench for mcu0_intc: table-driven vectors with a scoreboard
// queue, plus hand-written sequences for nesting, ack/edge collision,
// mid-operation reset and the optional ack timeout (INTC_TIMEOUT_EN).
module tb_mcu0_intc;

    typedef struct packed {
        logic [7:0] src;
        logic       mwe;
        logic [7:0] mwd;
        logic       ack;
        logic       eoi;
        logic [7:0] e_mask;
        logic [7:0] e_pend;
        logic       e_int;
        logic [2:0] e_irq;
        logic       e_isv;
        logic       e_to;
    } vec_t;

    logic       clock;
    logic       reset;
    logic [7:0] src;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       interrupt;
    logic [2:0] irq;
    logic       ack;
    logic       eoi;
    logic       in_service;
`ifdef INTC_TIMEOUT_EN
    logic       timeout;
`endif

    int   n_vec;
    int   n_err;
    vec_t sb_q[$];
    vec_t tbl[$];

    mcu0_intc dut (
        .clock      (clock),
        .reset      (reset),
        .src        (src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .interrupt  (interrupt),
        .irq        (irq),
        .ack        (ack),
        .eoi        (eoi),
`ifdef INTC_TIMEOUT_EN
        .timeout    (timeout),
`endif
        .in_service (in_service)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [7:0] s, input logic we, input logic [7:0] wd,
                                input logic a, input logic e, input logic [7:0] em,
                                input logic [7:0] ep, input logic ei, input logic [2:0] eq,
                                input logic es, input logic et);
        vec_t v;
        v.src = s; v.mwe = we; v.mwd = wd; v.ack = a; v.eoi = e;
        v.e_mask = em; v.e_pend = ep; v.e_int = ei; v.e_irq = eq; v.e_isv = es; v.e_to = et;
        return v;
    endfunction

    task automatic cmp(input vec_t e, input string name);
        logic to_ok;
        logic to_act;
        to_ok  = 1'b1;
        to_act = 1'b0;
`ifdef INTC_TIMEOUT_EN
        to_act = timeout;
        to_ok  = (timeout === e.e_to);
`endif
        n_vec++;
        if (mask !== e.e_mask || pending !== e.e_pend || interrupt !== e.e_int ||
            irq !== e.e_irq || in_service !== e.e_isv || !to_ok) begin
            n_err++;
            $display("FAIL %s #%0d: got mask=%h pend=%h int=%b irq=%0d isv=%b to=%b, want mask=%h pend=%h int=%b irq=%0d isv=%b to=%b",
                     name, n_vec, mask, pending, interrupt, irq, in_service, to_act,
                     e.e_mask, e.e_pend, e.e_int, e.e_irq, e.e_isv, e.e_to);
        end
    endtask

    // Drive one cycle of inputs, then check the outputs after the edge.
    task automatic apply(input vec_t v, input string name);
        vec_t exp;
        @(negedge clock);
        src        = v.src;
        mask_we    = v.mwe;
        mask_wdata = v.mwd;
        ack        = v.ack;
        eoi        = v.eoi;
        sb_q.push_back(v);
        @(posedge clock);
        #1;
        exp = sb_q.pop_front();
        cmp(exp, name);
    endtask

    task automatic reset_check(input string name);
        @(negedge clock);
        #2 reset = 1'b1;
        src = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
        #1 cmp(mk(8'h00, 0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 0, 0), name);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        src = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
        #12 cmp(mk(8'h00, 0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 0, 0), "reset");
        @(negedge clock);
        reset = 1'b0;

        // Single source: unmask src[2], pulse, request, ack, eoi; stray ack/eoi in IDLE.
        tbl.push_back(mk(8'h00, 1, 8'hFB, 0, 0, 8'hFB, 8'h00, 0, 3'd0, 0, 0));
        tbl.push_back(mk(8'h04, 0, 8'h00, 0, 0, 8'hFB, 8'h00, 0, 3'd0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFB, 8'h00, 0, 3'd0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFB, 8'h00, 0, 3'd0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFB, 8'h04, 0, 3'd0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFB, 8'h04, 1, 3'd2, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFB, 8'h04, 1, 3'd2, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 8'hFB, 8'h00, 0, 3'd2, 1, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFB, 8'h00, 0, 3'd2, 1, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 8'hFB, 8'h00, 0, 3'd2, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 1, 8'hFB, 8'h00, 0, 3'd2, 0, 0));
        // Two simultaneous sources: irq 1 first, irq 5 after an idle cycle.
        tbl.push_back(mk(8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd2, 0, 0));
        tbl.push_back(mk(8'h22, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd2, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd2, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd2, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h22, 0, 3'd2, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h22, 1, 3'd1, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h20, 0, 3'd1, 1, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h20, 0, 3'd1, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h20, 1, 3'd5, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 3'd5, 1, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 3'd5, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd5, 0, 0));
        // Masked source accumulates pending; unmask delivers on the 2nd edge.
        tbl.push_back(mk(8'h00, 1, 8'hFF, 0, 0, 8'hFF, 8'h00, 0, 3'd5, 0, 0));
        tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 3'd5, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 3'd5, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 3'd5, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFF, 8'h08, 0, 3'd5, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hFF, 8'h08, 0, 3'd5, 0, 0));
        tbl.push_back(mk(8'h00, 1, 8'hF7, 0, 0, 8'hF7, 8'h08, 0, 3'd5, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 8'hF7, 8'h08, 1, 3'd3, 0, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 8'hF7, 8'h00, 0, 3'd3, 1, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 8'hF7, 8'h00, 0, 3'd3, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // No nesting: src[0] during SERV of irq 1 waits for eoi; stray ack in SERV.
        apply(mk(8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd3, 0, 0), "nest");
        apply(mk(8'h02, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd3, 0, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd3, 0, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd3, 0, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h02, 0, 3'd3, 0, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h02, 1, 3'd1, 0, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 3'd1, 1, 0), "nest");
        apply(mk(8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd1, 1, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd1, 1, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd1, 1, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 3'd1, 1, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h01, 0, 3'd1, 1, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 3'd1, 0, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 3'd0, 0, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 3'd0, 1, 0), "nest");
        apply(mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 3'd0, 0, 0), "nest");

        // New src[4] edge lands in the ack cycle (ack+eoi together): set wins.
        apply(mk(8'h10, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h10, 0, 3'd0, 0, 0), "collide");
        apply(mk(8'h10, 0, 8'h00, 0, 0, 8'h00, 8'h10, 1, 3'd4, 0, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h10, 1, 3'd4, 0, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h10, 1, 3'd4, 0, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 1, 1, 8'h00, 8'h10, 0, 3'd4, 1, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h10, 0, 3'd4, 1, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h10, 0, 3'd4, 0, 0), "collide");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h10, 1, 3'd4, 0, 0), "collide");

        // Reset while a request is outstanding discards everything at once.
        reset_check("midop_reset");

        // Hold a request with no ack.
        apply(mk(8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 0), "hold");
        apply(mk(8'h40, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 0), "hold");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 0), "hold");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3'd0, 0, 0), "hold");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h40, 0, 3'd0, 0, 0), "hold");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h40, 1, 3'd6, 0, 0), "hold");
        for (int i = 1; i < 16; i++) begin
            apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h40, 1, 3'd6, 0, 0), "hold");
        end
`ifdef INTC_TIMEOUT_EN
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h40, 0, 3'd6, 0, 1), "timeout");
        apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h40, 1, 3'd6, 0, 1), "timeout");
        apply(mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 3'd6, 1, 1), "timeout");
        apply(mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 3'd6, 0, 1), "timeout");
`else
        for (int i = 0; i < 8; i++) begin
            apply(mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h40, 1, 3'd6, 0, 0), "hold");
        end
        apply(mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 3'd6, 1, 0), "hold");
        apply(mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 3'd6, 0, 0), "hold");
`endif
        reset_check("final_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
